// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite slave backed by a word-organised SRAM array
//
// Purpose:
//   Accepts AHB-Lite transfers, inserts WAIT_STATES wait cycles per data phase,
//   performs byte/halfword/word writes with little-endian lane steering and
//   returns full-word read data. The optional macro AHB_SRAM_ERR_EN compiles in
//   illegal-access detection and the two-cycle ERROR response (ERR1/ERR2).
//   Without it HRESP is tied low, the offset wraps inside the array, HSIZE>2
//   acts as a word and misaligned low address bits are aligned down to size.
//
// Parameters:
//   MEM_DEPTH   - number of 32-bit words (byte window MEM_DEPTH*4)
//   WAIT_STATES - wait cycles per accepted NONSEQ/SEQ transfer (0..7)
//
// Ports:
//   HCLK      in   bus clock, all state on the rising edge
//   HRESET    in   asynchronous active-high reset
//   HSEL      in   slave select from the decoder
//   HADDR     in   [31:0] address (offset bits only are used)
//   HTRANS    in   [1:0] IDLE/BUSY/NONSEQ/SEQ
//   HWRITE    in   1 = write
//   HSIZE     in   [2:0] 0 byte, 1 halfword, 2 word
//   HBURST    in   [2:0] accepted, not decoded (address taken per beat)
//   HWDATA    in   [31:0] write data, data phase
//   HREADY    in   bus-level ready
//   HREADYOUT out  this slave's ready
//   HRESP     out  0 OKAY, 1 ERROR
//   HRDATA    out  [31:0] read data
module ahb_sram_slave #(
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int          AW        = $clog2(MEM_DEPTH);
  localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);
  localparam logic [AW:0] DEPTH_W   = (AW+1)'(MEM_DEPTH);
  localparam bit          HAS_WAIT  = (WAIT_STATES != 0);

`ifdef AHB_SRAM_ERR_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW+1:0]   r_addr;
  logic            r_write;
  logic [2:0]      r_size;
  logic            r_pend;     // legal data phase in progress
  logic [2:0]      r_cnt;
  logic [31:0]     r_mem [MEM_DEPTH];

  logic            w_ready;
  logic            w_resp;
  logic            w_take;
  logic            w_illegal;
  logic            w_commit;
  logic [3:0]      w_be;
  logic [31:0]     w_wmask;
  logic [AW-1:0]   w_idx_raw;
  logic [AW-1:0]   w_idx;

`ifdef AHB_SRAM_ERR_EN
  localparam logic [AW+2:0] OFF_LIMIT = (AW+3)'(MEM_DEPTH * 4);
  logic [AW+2:0] w_off_ext;
  // One bit above the offset field is examined so the first alias past the
  // array is caught; the remaining upper bits belong to the bus decoder.
  assign w_off_ext = HADDR[AW+2:0];
  assign w_illegal = (w_off_ext >= OFF_LIMIT) || (HSIZE > 3'd2) ||
                     ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  logic [31-(AW+3):0] w_unused_addr;
  assign w_unused_addr = HADDR[31:AW+3];
`else
  assign w_illegal = 1'b0;
  logic [31-(AW+2):0] w_unused_addr;
  assign w_unused_addr = HADDR[31:AW+2];
`endif

  logic [2:0] w_unused_burst;
  assign w_unused_burst = HBURST;

  // Ready/response are a function of the data-phase state only.
  always_comb begin
    w_ready = 1'b1;
    w_resp  = 1'b0;
    case (r_state)
      S_WAIT: w_ready = (r_cnt == 3'd0);
`ifdef AHB_SRAM_ERR_EN
      S_ERR1: begin
        w_ready = 1'b0;
        w_resp  = 1'b1;
      end
      S_ERR2: w_resp = 1'b1;
`endif
      default: ;
    endcase
  end

  // New transfers are only taken when the current data phase is finishing,
  // so a BUSY/SEQ presented during wait cycles has no effect on this beat.
  assign w_take = HSEL && HREADY && HTRANS[1] && w_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (w_ready) begin
      if (w_take && w_illegal) begin
`ifdef AHB_SRAM_ERR_EN
        w_state_nxt = S_ERR1;
`else
        w_state_nxt = S_IDLE;
`endif
      end else if (w_take && HAS_WAIT) begin
        w_state_nxt = S_WAIT;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else begin
`ifdef AHB_SRAM_ERR_EN
      if (r_state == S_ERR1) w_state_nxt = S_ERR2;
`endif
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take && !w_illegal) begin
        r_addr  <= HADDR[AW+1:0];
        r_write <= HWRITE;
        r_size  <= HSIZE;
        r_cnt   <= WAIT_INIT;
      end else if (r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_ready) r_pend <= w_take && !w_illegal;
    end
  end

  // Lane enables; sizes above word act as word and low bits align down.
  always_comb begin
    w_be = 4'b1111;
    case (r_size)
      3'd0:    w_be = 4'b0001 << r_addr[1:0];
      3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_wmask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

  // Offset field can exceed the array only for non-power-of-two depths; a
  // single subtraction then gives the modulo wrap.
  assign w_idx_raw = r_addr[AW+1:2];
  assign w_idx     = ({1'b0, w_idx_raw} >= DEPTH_W) ? (w_idx_raw - DEPTH_W[AW-1:0])
                                                    : w_idx_raw;

  // Commit on the edge that ends the write data phase; a reset clears r_pend
  // first, so an interrupted write never lands.
  assign w_commit = r_pend && r_write && w_ready;

  always_ff @(posedge HCLK) begin
    if (w_commit) r_mem[w_idx] <= (r_mem[w_idx] & ~w_wmask) | (HWDATA & w_wmask);
  end

  assign HREADYOUT = w_ready;
  assign HRESP     = w_resp;
  assign HRDATA    = (r_pend && !r_write) ? r_mem[w_idx] : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed bench for ahb_sram_slave (W=0, W=2, W=1 instances)
module tb_ahb_sram_slave;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        hsel_bus;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  int          cur;

  logic        w_hro   [3];
  logic        w_hresp [3];
  logic [31:0] w_hrdata[3];
  logic        w_hsel  [3];
  logic        cur_ready, cur_resp;
  logic [31:0] cur_rdata;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] obs_rdata;
  logic        obs_resp, obs_low_resp;
  int          obs_waits;

  always #5 HCLK = ~HCLK;

  assign cur_ready = w_hro[cur];
  assign cur_resp  = w_hresp[cur];
  assign cur_rdata = w_hrdata[cur];
  assign w_hsel[0] = hsel_bus && (cur == 0);
  assign w_hsel[1] = hsel_bus && (cur == 1);
  assign w_hsel[2] = hsel_bus && (cur == 2);

  ahb_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(w_hsel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(cur_ready),
    .HREADYOUT(w_hro[0]), .HRESP(w_hresp[0]), .HRDATA(w_hrdata[0]));

  ahb_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(2)) u_dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(w_hsel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(cur_ready),
    .HREADYOUT(w_hro[1]), .HRESP(w_hresp[1]), .HRDATA(w_hrdata[1]));

  ahb_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(1)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(w_hsel[2]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(cur_ready),
    .HREADYOUT(w_hro[2]), .HRESP(w_hresp[2]), .HRDATA(w_hrdata[2]));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one address phase while the previous transfer's data phase runs
  // with the given HWDATA; returns after the edge on which both complete.
  task automatic bus_cycle(input logic [1:0] trans, input logic [31:0] addr, input logic wr,
                           input logic [2:0] size, input logic [31:0] wdata);
    bit done;
    done         = 1'b0;
    hsel_bus     = 1'b1;
    HTRANS       = trans;
    HADDR        = addr;
    HWRITE       = wr;
    HSIZE        = size;
    HWDATA       = wdata;
    obs_waits    = 0;
    obs_low_resp = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge HCLK);
      obs_rdata = cur_rdata;
      obs_resp  = cur_resp;
      if (cur_ready) done = 1'b1;
      else begin
        obs_waits++;
        obs_low_resp = obs_low_resp | obs_resp;
      end
    end
    if (!done) check_val("bus_timeout", {31'b0, cur_ready}, 32'd1);
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1; hsel_bus = 1'b0; HADDR = '0; HTRANS = T_IDLE; HWRITE = 1'b0;
    HSIZE = SZ_W; HBURST = 3'd0; HWDATA = '0; cur = 0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check_val("rst_hreadyout", {31'b0, w_hro[1]}, 32'd1);
    check_val("rst_hresp",     {31'b0, w_hresp[1]}, 32'd0);
    check_val("rst_hrdata",    w_hrdata[1], 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // W=0 back-to-back write then read
    cur = 0;
    bus_cycle(T_NSEQ, 32'h10, 1'b1, SZ_W, 32'h0);
    bus_cycle(T_NSEQ, 32'h10, 1'b0, SZ_W, 32'hDEADBEEF);
    check_val("w0_wr_waits", obs_waits, 0);
    check_val("w0_wr_resp", {31'b0, obs_resp}, 32'd0);
    check_val("w0_wr_rdata_zero", obs_rdata, 32'd0);
    bus_cycle(T_IDLE, 32'h0, 1'b0, SZ_W, 32'h0);
    check_val("w0_rd_waits", obs_waits, 0);
    check_val("w0_rd_data", obs_rdata, 32'hDEADBEEF);
    check_val("w0_rd_resp", {31'b0, obs_resp}, 32'd0);

    // Byte and halfword lane steering
    bus_cycle(T_NSEQ, 32'h30, 1'b1, SZ_W, 32'h0);
    bus_cycle(T_NSEQ, 32'h33, 1'b1, SZ_B, 32'h11223344);
    bus_cycle(T_NSEQ, 32'h30, 1'b0, SZ_W, 32'hAA000000);
    bus_cycle(T_NSEQ, 32'h30, 1'b1, SZ_H, 32'h0);
    check_val("byte_lane_rd", obs_rdata, 32'hAA223344);
    bus_cycle(T_NSEQ, 32'h30, 1'b0, SZ_W, 32'h99995566);
    bus_cycle(T_IDLE, 32'h0, 1'b0, SZ_W, 32'h0);
    check_val("half_lane_rd", obs_rdata, 32'hAA225566);

    // Out-of-window and misaligned accesses
    bus_cycle(T_NSEQ, 32'h0, 1'b1, SZ_W, 32'h0);
    bus_cycle(T_NSEQ, 32'h1000, 1'b1, SZ_W, 32'hCAFEF00D);
    bus_cycle(T_NSEQ, 32'h1000, 1'b0, SZ_W, 32'h13572468);
`ifdef AHB_SRAM_ERR_EN
    check_val("oob_wr_waits", obs_waits, 1);
    check_val("oob_wr_resp1", {31'b0, obs_low_resp}, 32'd1);
    check_val("oob_wr_resp2", {31'b0, obs_resp}, 32'd1);
`else
    check_val("oob_wr_waits", obs_waits, 0);
    check_val("oob_wr_resp", {31'b0, obs_resp}, 32'd0);
`endif
    bus_cycle(T_NSEQ, 32'h0, 1'b0, SZ_W, 32'h0);
`ifdef AHB_SRAM_ERR_EN
    check_val("oob_rd_waits", obs_waits, 1);
    check_val("oob_rd_resp", {31'b0, obs_resp}, 32'd1);
    check_val("oob_rd_rdata", obs_rdata, 32'd0);
`else
    check_val("oob_rd_alias", obs_rdata, 32'h13572468);
`endif
    bus_cycle(T_NSEQ, 32'h2, 1'b0, SZ_W, 32'h0);
`ifdef AHB_SRAM_ERR_EN
    check_val("oob_mem_unchanged", obs_rdata, 32'hCAFEF00D);
`else
    check_val("oob_mem_aliased", obs_rdata, 32'h13572468);
`endif
    bus_cycle(T_IDLE, 32'h0, 1'b0, SZ_W, 32'h0);
`ifdef AHB_SRAM_ERR_EN
    check_val("misalign_waits", obs_waits, 1);
    check_val("misalign_resp1", {31'b0, obs_low_resp}, 32'd1);
    check_val("misalign_resp2", {31'b0, obs_resp}, 32'd1);
`else
    check_val("misalign_rd", obs_rdata, 32'h13572468);
    check_val("misalign_resp", {31'b0, obs_resp}, 32'd0);
`endif

    // W=2 single write and read
    cur = 1;
    bus_cycle(T_NSEQ, 32'h20, 1'b1, SZ_W, 32'h0);
    bus_cycle(T_NSEQ, 32'h20, 1'b0, SZ_W, 32'h12345678);
    check_val("w2_wr_waits", obs_waits, 2);
    bus_cycle(T_IDLE, 32'h0, 1'b0, SZ_W, 32'h0);
    check_val("w2_rd_waits", obs_waits, 2);
    check_val("w2_rd_data", obs_rdata, 32'h12345678);
    bus_cycle(T_IDLE, 32'h0, 1'b0, SZ_W, 32'h0);
    check_val("w2_idle_waits", obs_waits, 0);

    // W=1 INCR4 burst with BUSY between beats 2 and 3
    cur = 2;
    HBURST = 3'b011;
    bus_cycle(T_NSEQ, 32'h40, 1'b1, SZ_W, 32'h0);
    bus_cycle(T_SEQ,  32'h44, 1'b1, SZ_W, 32'hA0A0A0A0);
    check_val("burst_b0_waits", obs_waits, 1);
    bus_cycle(T_BUSY, 32'h48, 1'b1, SZ_W, 32'hB1B1B1B1);
    check_val("burst_b1_waits", obs_waits, 1);
    bus_cycle(T_SEQ,  32'h48, 1'b1, SZ_W, 32'hEEEEEEEE);
    check_val("burst_busy_waits", obs_waits, 0);
    check_val("burst_busy_resp", {31'b0, obs_resp}, 32'd0);
    bus_cycle(T_SEQ,  32'h4C, 1'b1, SZ_W, 32'hC2C2C2C2);
    check_val("burst_b2_waits", obs_waits, 1);
    bus_cycle(T_IDLE, 32'h0,  1'b0, SZ_W, 32'hD3D3D3D3);
    check_val("burst_b3_waits", obs_waits, 1);
    bus_cycle(T_NSEQ, 32'h40, 1'b0, SZ_W, 32'h0);
    bus_cycle(T_SEQ,  32'h44, 1'b0, SZ_W, 32'h0);
    check_val("burst_rd0", obs_rdata, 32'hA0A0A0A0);
    bus_cycle(T_SEQ,  32'h48, 1'b0, SZ_W, 32'h0);
    check_val("burst_rd1", obs_rdata, 32'hB1B1B1B1);
    bus_cycle(T_SEQ,  32'h4C, 1'b0, SZ_W, 32'h0);
    check_val("burst_rd2", obs_rdata, 32'hC2C2C2C2);
    bus_cycle(T_IDLE, 32'h0,  1'b0, SZ_W, 32'h0);
    check_val("burst_rd3", obs_rdata, 32'hD3D3D3D3);
    HBURST = 3'd0;

    // Reset during a wait-state write on the W=2 instance
    cur = 1;
    bus_cycle(T_NSEQ, 32'h50, 1'b1, SZ_W, 32'h0);
    bus_cycle(T_IDLE, 32'h0,  1'b0, SZ_W, 32'h0BADF00D);
    bus_cycle(T_NSEQ, 32'h50, 1'b1, SZ_W, 32'h0);
    HTRANS = T_IDLE;
    HWDATA = 32'hFFFF0000;
    @(negedge HCLK);
    check_val("rstw_pre_hro", {31'b0, cur_ready}, 32'd0);
    #2 HRESET = 1'b1;
    #1;
    check_val("rstw_hro", {31'b0, cur_ready}, 32'd1);
    check_val("rstw_hresp", {31'b0, cur_resp}, 32'd0);
    check_val("rstw_hrdata", cur_rdata, 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    bus_cycle(T_NSEQ, 32'h50, 1'b0, SZ_W, 32'h0);
    bus_cycle(T_IDLE, 32'h0,  1'b0, SZ_W, 32'h0);
    check_val("rstw_prior_value", obs_rdata, 32'h0BADF00D);

    // Reset during a wait-state read: read data must vanish at once
    bus_cycle(T_NSEQ, 32'h20, 1'b0, SZ_W, 32'h0);
    HTRANS = T_IDLE;
    @(negedge HCLK);
    check_val("rstr_pre_rdata", cur_rdata, 32'h12345678);
    #2 HRESET = 1'b1;
    #1;
    check_val("rstr_hrdata", cur_rdata, 32'd0);
    check_val("rstr_hro", {31'b0, cur_ready}, 32'd1);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    bus_cycle(T_IDLE, 32'h0, 1'b0, SZ_W, 32'h0);
    check_val("rstr_post_waits", obs_waits, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
